// File: rtl/sig_edge_timestamp.sv
// Per-channel detector front end: 2-FF synchronizer, glitch filter, free-running timestamp and edge capture.
// Build option: define SIG_GLITCH_COUNT_EN to add the saturating glitch_count output.
module sig_edge_timestamp #(
  parameter int TS_WIDTH   = 32,
  parameter int FILTER_LEN = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sig_in,
  input  logic                enable,
  input  logic                ts_clear,
  output logic [TS_WIDTH-1:0] sig_time,
  output logic                sig_rise,
  output logic                sig_fall,
  output logic                sig_level,
  output logic [TS_WIDTH-1:0] ts_now
`ifdef SIG_GLITCH_COUNT_EN
  ,
  output logic [15:0]         glitch_count
`endif
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [7:0]          CNT_LAST     = 8'(FILTER_LEN - 1);
  localparam bit                  SINGLE_STAGE = (FILTER_LEN == 1);
  localparam logic [TS_WIDTH-1:0] TS_ZERO      = {TS_WIDTH{1'b0}};
  localparam logic [TS_WIDTH-1:0] TS_ONE       = TS_WIDTH'(1);

  logic                sync1_r;
  logic                sync2_r;
  logic [TS_WIDTH-1:0] ts_r;
  logic [TS_WIDTH-1:0] cand_r;
  logic [7:0]          cnt_r;
  state_t              state_r;
  logic                disagree_s;

  assign disagree_s = (sync2_r != sig_level) && enable;
  assign ts_now     = ts_r;

  // Two-flop synchronizer for the asynchronous detector input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= sig_in;
      sync2_r <= sync1_r;
    end
  end

  // Free-running timestamp, shared clear keeps L/R channels comparable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_r <= TS_ZERO;
    end else if (ts_clear) begin
      ts_r <= TS_ZERO;
    end else begin
      ts_r <= ts_r + TS_ONE;
    end
  end

  // Glitch filter FSM; cand_r holds the timestamp of the first disagreeing sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_STABLE;
      cnt_r     <= 8'd0;
      cand_r    <= TS_ZERO;
      sig_time  <= TS_ZERO;
      sig_rise  <= 1'b0;
      sig_fall  <= 1'b0;
      sig_level <= 1'b0;
    end else begin
      sig_rise <= 1'b0;
      sig_fall <= 1'b0;
      case (state_r)
        ST_STABLE: begin
          if (disagree_s && SINGLE_STAGE) begin
            sig_level <= sync2_r;
            sig_time  <= ts_r;
            sig_rise  <= sync2_r;
            sig_fall  <= ~sync2_r;
            cnt_r     <= 8'd0;
          end else if (disagree_s) begin
            cand_r  <= ts_r;
            cnt_r   <= 8'd1;
            state_r <= ST_PENDING;
          end else begin
            cnt_r <= 8'd0;
          end
        end
        ST_PENDING: begin
          if (disagree_s && (cnt_r == CNT_LAST)) begin
            sig_level <= sync2_r;
            sig_time  <= cand_r;
            sig_rise  <= sync2_r;
            sig_fall  <= ~sync2_r;
            cnt_r     <= 8'd0;
            state_r   <= ST_STABLE;
          end else if (disagree_s) begin
            cnt_r <= cnt_r + 8'd1;
          end else begin
            cnt_r   <= 8'd0;
            state_r <= ST_STABLE;
          end
        end
        default: begin
          cnt_r   <= 8'd0;
          state_r <= ST_STABLE;
        end
      endcase
    end
  end

`ifdef SIG_GLITCH_COUNT_EN
  logic glitch_s;

  // Only an input reversion counts; an enable drop also aborts but is not a glitch
  assign glitch_s = (state_r == ST_PENDING) && !disagree_s && enable;

  // Saturating glitch counter, cleared together with the timestamp
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_count <= 16'h0000;
    end else if (ts_clear) begin
      glitch_count <= 16'h0000;
    end else if (glitch_s && (glitch_count != 16'hFFFF)) begin
      glitch_count <= glitch_count + 16'h0001;
    end else begin
      glitch_count <= glitch_count;
    end
  end
`endif

endmodule

// File: tb/tb_sig_edge_timestamp.sv
// Scoreboard bench: two channels (FILTER_LEN 4 and 1) checked against a sliding-window reference model.
module tb_sig_edge_timestamp;

  localparam int TW  = 10;
  localparam int FL0 = 4;
  localparam int FL1 = 1;
  localparam int HN  = 4096;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sig_in = 1'b0;
  logic enable = 1'b0;
  logic ts_clear = 1'b0;

  logic [TW-1:0] sig_time0, ts_now0, sig_time1, ts_now1;
  logic          sig_rise0, sig_fall0, sig_level0;
  logic          sig_rise1, sig_fall1, sig_level1;
`ifdef SIG_GLITCH_COUNT_EN
  logic [15:0]   glitch_count0, glitch_count1;
  logic [15:0]   m_glitch [2];
`endif

  typedef struct {
    int            ch;
    bit            rise;
    logic [TW-1:0] t;
    int            due;
  } pulse_t;

  pulse_t        exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            m_sync1, m_sync2;
  logic [TW-1:0] m_ts;
  bit            m_level [2];
  logic [TW-1:0] m_time [2];
  int            valid_from [2];
  bit            hist_d [2][HN];
  logic [TW-1:0] hist_ts [HN];
  int            m_fl, m_start;
  bit            m_d, m_all;
  pulse_t        m_p;

  sig_edge_timestamp #(.TS_WIDTH(TW), .FILTER_LEN(FL0)) dut0 (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .enable(enable), .ts_clear(ts_clear),
    .sig_time(sig_time0), .sig_rise(sig_rise0), .sig_fall(sig_fall0), .sig_level(sig_level0),
    .ts_now(ts_now0)
`ifdef SIG_GLITCH_COUNT_EN
    , .glitch_count(glitch_count0)
`endif
  );

  sig_edge_timestamp #(.TS_WIDTH(TW), .FILTER_LEN(FL1)) dut1 (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .enable(enable), .ts_clear(ts_clear),
    .sig_time(sig_time1), .sig_rise(sig_rise1), .sig_fall(sig_fall1), .sig_level(sig_level1),
    .ts_now(ts_now1)
`ifdef SIG_GLITCH_COUNT_EN
    , .glitch_count(glitch_count1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an edge is accepted once the last FILTER_LEN samples since the
  // previous acceptance (or reset) all disagree with the level while enabled.
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_sync1 = 1'b0;
      m_sync2 = 1'b0;
      m_ts    = '0;
      for (int ch = 0; ch < 2; ch++) begin
        m_level[ch]    = 1'b0;
        m_time[ch]     = '0;
        valid_from[ch] = cyc;
`ifdef SIG_GLITCH_COUNT_EN
        m_glitch[ch]   = 16'h0000;
`endif
      end
      exp_q.delete();
    end else begin
      hist_ts[cyc % HN] = m_ts;
      for (int ch = 0; ch < 2; ch++) begin
        m_fl  = (ch == 0) ? FL0 : FL1;
        m_d   = enable && (m_sync2 != m_level[ch]);
        hist_d[ch][cyc % HN] = m_d;
        m_start = cyc - m_fl + 1;
        m_all   = (m_start >= valid_from[ch]);
        for (int k = m_start; k <= cyc && m_all; k++)
          if (!hist_d[ch][k % HN]) m_all = 1'b0;
        if (m_all) begin
          m_p.ch   = ch;
          m_p.rise = m_sync2;
          m_p.t    = hist_ts[m_start % HN];
          m_p.due  = cyc + 1;
          exp_q.push_back(m_p);
          m_level[ch]    = m_sync2;
          m_time[ch]     = m_p.t;
          valid_from[ch] = cyc + 1;
        end
`ifdef SIG_GLITCH_COUNT_EN
        else if (!m_d && enable && (cyc - 1 >= valid_from[ch]) && hist_d[ch][(cyc - 1) % HN]
                 && m_glitch[ch] != 16'hFFFF)
          m_glitch[ch] = m_glitch[ch] + 16'h0001;
        if (ts_clear) m_glitch[ch] = 16'h0000;
`endif
      end
      m_ts    = ts_clear ? '0 : m_ts + 10'd1;
      m_sync2 = m_sync1;
      m_sync1 = sig_in;
      cyc++;
    end
  end

  task automatic check_chan(input int ch, input logic r, input logic f, input logic lv,
                            input logic [TW-1:0] st, input logic [TW-1:0] tn);
    bit            exp_p = 1'b0;
    bit            exp_r = 1'b0;
    logic [TW-1:0] exp_t = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].ch == ch && exp_q[i].due == cyc) begin
        exp_p = 1'b1;
        exp_r = exp_q[i].rise;
        exp_t = exp_q[i].t;
        exp_q.delete(i);
        break;
      end
    end
    chk($sformatf("ch%0d_rise", ch), {31'd0, r}, {31'd0, exp_p && exp_r});
    chk($sformatf("ch%0d_fall", ch), {31'd0, f}, {31'd0, exp_p && !exp_r});
    if (exp_p) chk($sformatf("ch%0d_pulse_time", ch), 32'(st), 32'(exp_t));
    chk($sformatf("ch%0d_sig_time", ch), 32'(st), 32'(m_time[ch]));
    chk($sformatf("ch%0d_level", ch), {31'd0, lv}, {31'd0, m_level[ch]});
    chk($sformatf("ch%0d_ts_now", ch), 32'(tn), 32'(m_ts));
  endtask

  // Monitor: compares DUT outputs with the scoreboard away from the active edge
  initial forever begin
    @(negedge clk);
    check_chan(0, sig_rise0, sig_fall0, sig_level0, sig_time0, ts_now0);
    check_chan(1, sig_rise1, sig_fall1, sig_level1, sig_time1, ts_now1);
`ifdef SIG_GLITCH_COUNT_EN
    chk("ch0_glitch_count", 32'(glitch_count0), 32'(m_glitch[0]));
    chk("ch1_glitch_count", 32'(glitch_count1), 32'(m_glitch[1]));
`endif
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_ts(input logic [TW-1:0] t);
    int guard = 0;
    while (m_ts != t && guard < 3000) begin
      step(1);
      guard++;
    end
    chk("wait_ts_timeout", 32'(m_ts), 32'(t));
  endtask

  initial begin
    int run = 0;
    step(3);
    chk("reset_ts_now", 32'(ts_now0), 32'd0);
    chk("reset_level", {31'd0, sig_level0}, 32'd0);
    chk("reset_sig_time", 32'(sig_time0), 32'd0);
    reset_n = 1'b1;
    step(2);
    enable   = 1'b1;
    ts_clear = 1'b1;
    step(1);
    ts_clear = 1'b0;

    // Rise: s high from ts=100
    wait_ts(10'd98);  sig_in = 1'b1;
    wait_ts(10'd150);
    chk("rise_time_f4", 32'(sig_time0), 32'd100);
    chk("rise_level_f4", {31'd0, sig_level0}, 32'd1);
    chk("rise_time_f1", 32'(sig_time1), 32'd100);

    // Three-sample glitch low at ts=200..202
    wait_ts(10'd198); sig_in = 1'b0;
    wait_ts(10'd201); sig_in = 1'b1;
    wait_ts(10'd250);
    chk("glitch_time_f4", 32'(sig_time0), 32'd100);
    chk("glitch_level_f4", {31'd0, sig_level0}, 32'd1);
`ifdef SIG_GLITCH_COUNT_EN
    chk("glitch_count_f4", 32'(glitch_count0), 32'd1);
`endif

    // Fall: s low from ts=300
    wait_ts(10'd298); sig_in = 1'b0;
    wait_ts(10'd350);
    chk("fall_time_f4", 32'(sig_time0), 32'd300);
    chk("fall_level_f4", {31'd0, sig_level0}, 32'd0);

    // Edge straddling the counter wrap
    wait_ts(10'h3FC); sig_in = 1'b1;
    wait_ts(10'd20);
    chk("wrap_time_f4", 32'(sig_time0), 32'h3FE);
    sig_in = 1'b0;

    // Reset while an edge is pending
    wait_ts(10'd398); sig_in = 1'b1;
    wait_ts(10'd402);
    reset_n = 1'b0;
    #1;
    chk("rst_rise_f4", {31'd0, sig_rise0}, 32'd0);
    chk("rst_level_f4", {31'd0, sig_level0}, 32'd0);
    chk("rst_time_f4", 32'(sig_time0), 32'd0);
    chk("rst_ts_f4", 32'(ts_now0), 32'd0);
    chk("rst_time_f1", 32'(sig_time1), 32'd0);
    step(3);
    reset_n = 1'b1;
    step(10);
    chk("post_rst_time_f4", 32'(sig_time0), 32'd2);
    chk("post_rst_level_f4", {31'd0, sig_level0}, 32'd1);
    chk("post_rst_time_f1", 32'(sig_time1), 32'd2);

    // Randomized phase
    for (int i = 0; i < 2500; i++) begin
      if (run == 0) begin
        sig_in = 1'($urandom_range(1, 0));
        run    = int'($urandom_range(7, 1));
      end
      run--;
      enable   = ($urandom_range(15, 0) != 0);
      ts_clear = ($urandom_range(63, 0) == 0);
      if ($urandom_range(599, 0) == 0) begin
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
      end
      step(1);
    end
    enable   = 1'b0;
    ts_clear = 1'b0;
    step(8);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
